// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
//   Per-game sequencer for Tetris. It spawns pieces from a 7-bit LFSR and
//   runs the mover START/DONE handshake. It then pulses the board lock and
//   scans the rows bottom-up, requesting one clear per full row. Finally it
//   updates the lines, level and score and detects game over.
//
//   Optional feature macro: SCORING_EN (defined -> score accumulates,
//   undefined -> score tied to 0, no multiplier).
//
// Ports
//   CLK, RESET     clock; synchronous active-high reset
//   new_game       pulse, starts a game from Idle or GameOver
//   move_start     level START to the mover      / move_done  mover DONE
//   lock_start     1-cycle board write pulse     / lock_done  write complete
//   row_full       per-row full flags from the board
//   clear_row_req  row delete request, clear_row_idx row, clear_ack done
//   spawn_blocked  spawn position overlaps the board
//   piece_type     active piece; next_piece preview piece (0..6)
//   level, lines, score  game statistics
//   playing        high from Spawn through Score; game_over high in GameOver
module game_flow_ctrl #(
    parameter int unsigned NUM_ROWS        = 20,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 19,
    parameter logic [6:0]  LFSR_SEED       = 7'h5A
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                new_game,
    output logic                move_start,
    input  logic                move_done,
    output logic                lock_start,
    input  logic                lock_done,
    input  logic [NUM_ROWS-1:0] row_full,
    output logic                clear_row_req,
    output logic [4:0]          clear_row_idx,
    input  logic                clear_ack,
    input  logic                spawn_blocked,
    output logic [2:0]          piece_type,
    output logic [2:0]          next_piece,
    output logic [31:0]         level,
    output logic [15:0]         lines,
    output logic [31:0]         score,
    output logic                playing,
    output logic                game_over
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SPAWN,
        S_SPAWN_CHK,
        S_MOVE,
        S_LOCK,
        S_LOCK_WAIT,
        S_SCAN_WAIT,
        S_SCAN,
        S_CLEAR,
        S_SCORE,
        S_GAME_OVER
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start_game;

    logic [6:0]  r_lfsr;
    logic        r_draw_pend;
    logic [2:0]  r_piece;
    logic [2:0]  r_next_piece;
    logic [4:0]  r_idx;
    logic [2:0]  r_cleared;
    logic [15:0] r_lines;
    logic [31:0] r_level;
    logic [31:0] r_lil;

    logic [2:0]  w_draw;
    logic        w_draw_ok;
    logic [16:0] w_lines_sum;
    logic [31:0] w_lil_sum;

    assign w_draw      = r_lfsr[2:0];
    assign w_draw_ok   = (w_draw != 3'd7);
    assign w_lines_sum = {1'b0, r_lines} + {14'd0, r_cleared};
    assign w_lil_sum   = r_lil + {29'd0, r_cleared};

    assign piece_type  = r_piece;
    assign next_piece  = r_next_piece;
    assign level       = r_level;
    assign lines       = r_lines;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_game  = 1'b0;
        move_start    = 1'b0;
        lock_start    = 1'b0;
        clear_row_req = 1'b0;
        clear_row_idx = '0;
        playing       = 1'b0;
        game_over     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (new_game) begin
                    w_start_game = 1'b1;
                    w_next       = S_SPAWN;
                end
            end
            S_SPAWN: begin
                playing = 1'b1;
                w_next  = S_SPAWN_CHK;
            end
            S_SPAWN_CHK: begin
                playing = 1'b1;
                // A DONE still high from the previous piece must drop before
                // START is raised again.
                if (spawn_blocked) begin
                    w_next = S_GAME_OVER;
                end else if (!move_done) begin
                    w_next = S_MOVE;
                end
            end
            S_MOVE: begin
                playing    = 1'b1;
                move_start = 1'b1;
                if (move_done) begin
                    w_next = S_LOCK;
                end
            end
            S_LOCK: begin
                playing    = 1'b1;
                lock_start = 1'b1;
                w_next     = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                playing = 1'b1;
                if (lock_done) begin
                    w_next = S_SCAN_WAIT;
                end
            end
            S_SCAN_WAIT: begin
                playing = 1'b1;
                w_next  = S_SCAN;
            end
            S_SCAN: begin
                playing = 1'b1;
                if (row_full[r_idx]) begin
                    w_next = S_CLEAR;
                end else if (r_idx == 5'd0) begin
                    w_next = S_SCORE;
                end
            end
            S_CLEAR: begin
                playing       = 1'b1;
                clear_row_req = 1'b1;
                clear_row_idx = r_idx;
                // Rescan the same index: the rows above have moved into it.
                if (clear_ack) begin
                    w_next = S_SCAN_WAIT;
                end
            end
            S_SCORE: begin
                playing = 1'b1;
                w_next  = S_SPAWN;
            end
            S_GAME_OVER: begin
                game_over = 1'b1;
                if (new_game) begin
                    w_start_game = 1'b1;
                    w_next       = S_SPAWN;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_lfsr       <= LFSR_SEED;
            r_draw_pend  <= 1'b1;
            r_piece      <= '0;
            r_next_piece <= '0;
            r_idx        <= 5'(NUM_ROWS - 1);
            r_cleared    <= '0;
            r_lines      <= '0;
            r_level      <= '0;
            r_lil        <= '0;
        end else begin
            // x^7 + x^6 + 1
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

            // A draw of 7 leaves the preview unchanged and retries each
            // cycle until a legal piece comes up.
            if (r_state == S_SPAWN) begin
                r_piece     <= r_next_piece;
                r_draw_pend <= !w_draw_ok;
                if (w_draw_ok) begin
                    r_next_piece <= w_draw;
                end
            end else if (r_draw_pend && w_draw_ok) begin
                r_next_piece <= w_draw;
                r_draw_pend  <= 1'b0;
            end

            if (w_start_game) begin
                r_lfsr  <= LFSR_SEED;
                r_lines <= '0;
                r_level <= '0;
                r_lil   <= '0;
            end

            if (r_state == S_LOCK_WAIT && lock_done) begin
                r_cleared <= '0;
                r_idx     <= 5'(NUM_ROWS - 1);
            end

            if (r_state == S_SCAN && !row_full[r_idx] && r_idx != 5'd0) begin
                r_idx <= r_idx - 5'd1;
            end

            if (r_state == S_CLEAR && clear_ack && r_cleared != 3'd4) begin
                r_cleared <= r_cleared + 3'd1;
            end

            if (r_state == S_SCORE) begin
                r_lines <= w_lines_sum[16] ? 16'hFFFF : w_lines_sum[15:0];
                if (w_lil_sum >= LINES_PER_LEVEL) begin
                    r_lil <= w_lil_sum - LINES_PER_LEVEL;
                    if (r_level < MAX_LEVEL) begin
                        r_level <= r_level + 32'd1;
                    end
                end else begin
                    r_lil <= w_lil_sum;
                end
            end
        end
    end

`ifdef SCORING_EN
    logic [31:0] r_score;
    logic [10:0] w_base;
    logic [43:0] w_prod;
    logic [44:0] w_score_sum;

    always_comb begin
        case (r_cleared)
            3'd1:    w_base = 11'd40;
            3'd2:    w_base = 11'd100;
            3'd3:    w_base = 11'd300;
            3'd4:    w_base = 11'd1200;
            default: w_base = 11'd0;
        endcase
    end

    // Uses the level before this Score cycle's update.
    assign w_prod      = 44'(w_base) * (44'(r_level) + 44'd1);
    assign w_score_sum = 45'(r_score) + 45'(w_prod);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_score <= '0;
        end else if (w_start_game) begin
            r_score <= '0;
        end else if (r_state == S_SCORE) begin
            r_score <= (|w_score_sum[44:32]) ? 32'hFFFF_FFFF : w_score_sum[31:0];
        end
    end

    assign score = r_score;
`else
    assign score = '0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
`timescale 1ns/1ps
module tb_game_flow_ctrl;

    localparam int NROWS = 20;
    localparam int LPL   = 10;
    localparam int MAXL  = 19;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        new_game = 1'b0;
    logic        move_done = 1'b0;
    logic        lock_done = 1'b0;
    logic        clear_ack = 1'b0;
    logic        spawn_blocked = 1'b0;
    logic [19:0] row_full = '0;

    logic        move_start, lock_start, clear_row_req, playing, game_over;
    logic [4:0]  clear_row_idx;
    logic [2:0]  piece_type, next_piece;
    logic [31:0] level, score;
    logic [15:0] lines;

    game_flow_ctrl #(
        .NUM_ROWS(20),
        .LINES_PER_LEVEL(10),
        .MAX_LEVEL(19),
        .LFSR_SEED(7'h5A)
    ) dut (
        .CLK(CLK), .RESET(RESET), .new_game(new_game),
        .move_start(move_start), .move_done(move_done),
        .lock_start(lock_start), .lock_done(lock_done),
        .row_full(row_full),
        .clear_row_req(clear_row_req), .clear_row_idx(clear_row_idx),
        .clear_ack(clear_ack), .spawn_blocked(spawn_blocked),
        .piece_type(piece_type), .next_piece(next_piece),
        .level(level), .lines(lines), .score(score),
        .playing(playing), .game_over(game_over)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference game statistics and board contents
    longint      m_total, m_lines, m_level, m_score;
    logic [19:0] board;

    typedef struct {
        logic [5:0] in_bits;   // {RESET, new_game, spawn_blocked, move_done, lock_done, clear_ack}
        logic [4:0] ctl;       // {move_start, lock_start, clear_row_req, playing, game_over}
        logic       chk;
        logic [2:0] pt;
        logic [2:0] np;
    } vec_t;

    vec_t vt [0:10];

    function automatic vec_t mk(input logic [5:0] in_bits, input logic [4:0] ctl,
                                input logic chk, input logic [2:0] pt, input logic [2:0] np);
        vec_t v;
        v.in_bits = in_bits;
        v.ctl     = ctl;
        v.chk     = chk;
        v.pt      = pt;
        v.np      = np;
        return v;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge. Every cycle
    // the three requests must be mutually exclusive and pieces legal.
    task automatic tick();
        @(posedge CLK);
        #1;
        n_checks++;
        if ($countones({move_start, lock_start, clear_row_req}) > 1 ||
            piece_type > 3'd6 || next_piece > 3'd6) begin
            n_err++;
            $display("FAIL excl_range: ms=%0b ls=%0b cr=%0b pt=%0d np=%0d",
                     move_start, lock_start, clear_row_req, piece_type, next_piece);
        end
    endtask

    function automatic longint exp_score();
`ifdef SCORING_EN
        return m_score;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_total = 0;
        m_lines = 0;
        m_level = 0;
        m_score = 0;
    endtask

    task automatic model_update(input int n);
        longint base;
        longint lv0;
        lv0 = m_level;
        case (n)
            0: base = 0;
            1: base = 40;
            2: base = 100;
            3: base = 300;
            default: base = 1200;
        endcase
        m_total += (n > 4) ? 4 : n;
        m_lines = (m_total > 65535) ? 65535 : m_total;
        m_level = (m_total / LPL > MAXL) ? MAXL : m_total / LPL;
        m_score = m_score + base * (lv0 + 1);
        if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
    endtask

    // From ScanWait after the last trigger at scan index k: k+1 Scan cycles,
    // one Score cycle, then Spawn with the updated statistics.
    task automatic finish_tail(input int k, input int n);
        for (int i = 1; i <= k + 2; i++) begin
            tick();
            check("scan_quiet", {clear_row_req, lines}, {1'b0, 16'(m_lines)});
        end
        model_update(n);
        tick();
        check("lines", 96'(lines), 96'(m_lines));
        check("level", 96'(level), 96'(m_level));
        check("score", 96'(score), 96'(exp_score()));
    endtask

    // One piece, entered with the DUT in Spawn and left in the next Spawn.
    task automatic run_turn(input logic [19:0] brd, input int hold_chk, input int dly_move,
                            input int dly_lock, input int dly_clr, input bit abort_in_clear);
        int q[$];
        int removed;
        int k;
        int e;
        int nfull;
        logic [2:0] exp_pt;

        // Each originally full row is requested at its own index plus the
        // number of full rows below it that have already collapsed.
        removed = 0;
        for (int r = NROWS - 1; r >= 0; r--) begin
            if (brd[r]) begin
                q.push_back(r + removed);
                removed++;
            end
        end
        nfull = removed;

        exp_pt    = next_piece;
        move_done = (hold_chk > 0);
        tick();
        check("spawn_piece", 96'(piece_type), 96'(exp_pt));
        for (int i = 0; i < hold_chk; i++) begin
            tick();
            check("chk_hold", {move_start, lock_start, clear_row_req, playing}, 4'b0001);
        end
        move_done = 1'b0;
        tick();
        check("move_start", {move_start, lock_start, clear_row_req}, 3'b100);
        for (int i = 0; i < dly_move; i++) begin
            new_game = 1'($urandom_range(0, 1));
            tick();
            check("move_hold", {move_start, playing}, 2'b11);
        end
        new_game  = 1'b0;
        move_done = 1'b1;
        tick();
        check("lock_pulse", {move_start, lock_start}, 2'b01);
        move_done = 1'b0;
        tick();
        check("lock_single", {move_start, lock_start}, 2'b00);
        for (int i = 0; i < dly_lock; i++) begin
            tick();
            check("lock_wait", {move_start, lock_start, clear_row_req}, 3'b000);
        end
        lock_done = 1'b1;
        board     = brd;
        row_full  = brd;
        tick();
        lock_done = 1'b0;

        k = NROWS - 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            for (int i = 0; i < k - e + 1; i++) begin
                tick();
                check("pre_clear_quiet", 96'(clear_row_req), 96'(0));
            end
            tick();
            check("clear_req", {clear_row_req, clear_row_idx}, {1'b1, 5'(e)});
            if (abort_in_clear) begin
                RESET = 1'b1;
                tick();
                check("rst_ctl", {move_start, lock_start, clear_row_req, clear_row_idx,
                                  piece_type, next_piece, playing, game_over}, '0);
                check("rst_stats", {level, lines, score}, '0);
                RESET     = 1'b0;
                clear_ack = 1'b1;
                tick();
                check("rst_first_draw", 96'(next_piece), 96'(2));
                check("rst_ack_ignored", {move_start, lock_start, clear_row_req, playing,
                                          game_over, level, lines, score}, '0);
                tick();
                check("rst_ack_ignored2", {move_start, lock_start, clear_row_req, playing,
                                           game_over, lines}, '0);
                clear_ack = 1'b0;
                board     = '0;
                row_full  = '0;
                return;
            end
            for (int i = 0; i < dly_clr; i++) begin
                tick();
                check("clear_hold", {clear_row_req, clear_row_idx}, {1'b1, 5'(e)});
            end
            clear_ack = 1'b1;
            for (int r = e; r >= 1; r--) board[r] = board[r-1];
            board[0] = 1'b0;
            row_full = board;
            tick();
            clear_ack = 1'b0;
            check("clear_drop", 96'(clear_row_req), 96'(0));
            k = e;
        end
        finish_tail(k, nfull);
    endtask

    function automatic logic [19:0] rand_board(input int nfull);
        logic [19:0] b;
        int r;
        b = '0;
        while ($countones(b) < nfull) begin
            r = $urandom_range(0, NROWS - 1);
            b[r] = 1'b1;
        end
        return b;
    endfunction

    task automatic rand_turn(input int nfull, input bit abort_in_clear);
        run_turn(rand_board(nfull), $urandom_range(0, 2), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), abort_in_clear);
    endtask

    initial begin
        model_reset();
        board = '0;

        // Reset, new_game, first spawn and lock handshake, cycle by cycle.
        vt[0]  = mk(6'b100000, 5'b00000, 1'b1, 3'd0, 3'd0);
        vt[1]  = mk(6'b100000, 5'b00000, 1'b1, 3'd0, 3'd0);
        vt[2]  = mk(6'b000000, 5'b00000, 1'b1, 3'd0, 3'd2);
        vt[3]  = mk(6'b010000, 5'b00010, 1'b1, 3'd0, 3'd2);
        vt[4]  = mk(6'b000000, 5'b00010, 1'b1, 3'd2, 3'd2);
        vt[5]  = mk(6'b000000, 5'b10010, 1'b0, 3'd0, 3'd0);
        vt[6]  = mk(6'b000000, 5'b10010, 1'b0, 3'd0, 3'd0);
        vt[7]  = mk(6'b000100, 5'b01010, 1'b0, 3'd0, 3'd0);
        vt[8]  = mk(6'b000000, 5'b00010, 1'b0, 3'd0, 3'd0);
        vt[9]  = mk(6'b000101, 5'b00010, 1'b0, 3'd0, 3'd0);
        vt[10] = mk(6'b000010, 5'b00010, 1'b0, 3'd0, 3'd0);

        for (int i = 0; i < 11; i++) begin
            {RESET, new_game, spawn_blocked, move_done, lock_done, clear_ack} = vt[i].in_bits;
            tick();
            check($sformatf("vec%0d_ctl", i),
                  {move_start, lock_start, clear_row_req, playing, game_over}, vt[i].ctl);
            if (vt[i].chk) begin
                check($sformatf("vec%0d_piece", i), {piece_type, next_piece}, {vt[i].pt, vt[i].np});
            end
        end
        {RESET, new_game, spawn_blocked, move_done, lock_done, clear_ack} = 6'b000000;
        finish_tail(NROWS - 1, 0);

        // Two full bottom rows: both requests at row 19.
        run_turn(20'hC0000, 0, 1, 1, 2, 1'b0);
        check("two_line_lines", 96'(lines), 96'(2));
`ifdef SCORING_EN
        check("two_line_score", 96'(score), 96'(100));
`endif

        // Single-line clears up to 9 lines, then the tenth crosses a level.
        for (int i = 0; i < 7; i++) rand_turn(1, 1'b0);
        check("lines9_level", {lines, level}, {16'd9, 32'd0});
        rand_turn(1, 1'b0);
        check("lines10_level", {lines, level}, {16'd10, 32'd1});

        // Four-line clears well past the level ceiling.
        for (int i = 0; i < 48; i++) rand_turn(4, 1'b0);
        check("level_sat", 96'(level), 96'(19));

        for (int i = 0; i < 15; i++) rand_turn($urandom_range(0, 4), 1'b0);

        // Blocked spawn -> GameOver, stray responses ignored, restart.
        spawn_blocked = 1'b1;
        tick();
        check("go_chk", {move_start, playing, game_over}, 3'b010);
        tick();
        check("go_enter", {move_start, lock_start, clear_row_req, playing, game_over}, 5'b00001);
        move_done = 1'b1;
        lock_done = 1'b1;
        clear_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("go_hold", {move_start, lock_start, clear_row_req, playing, game_over, lines},
                  {5'b00001, 16'(m_lines)});
        end
        {move_done, lock_done, clear_ack, spawn_blocked} = 4'b0000;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check("restart_ctl", {move_start, playing, game_over}, 3'b010);
        check("restart_stats", {level, lines, score}, '0);
        model_reset();
        for (int i = 0; i < 3; i++) rand_turn($urandom_range(1, 4), 1'b0);

        // Reset while a clear is pending, then a fresh game.
        rand_turn(2, 1'b1);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_reset();
        rand_turn($urandom_range(0, 4), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level sequencer for one game of Tetris. It spawns pieces, drives the piece mover through its START/DONE handshake, and commands the board to lock the settled piece. It then scans for full rows and requests each clear, and updates the lines count, level and score. It also detects game over. It sits between the keyboard/top FSM and the mover, board-write and row-clear datapaths, and supplies the `level` and `piece_type` inputs to the mover.

Parameters:
NUM_ROWS, 20, playfield rows; row index 0 is the top row.
LINES_PER_LEVEL, 10, cleared lines per level increment.
MAX_LEVEL, 19, saturation value of level.
LFSR_SEED, 7'h5A, reset and new-game seed of the piece LFSR (must be nonzero).

Ports:
CLK  in  1  system clock; all state updates on posedge.
RESET  in  1  synchronous, active-high; sampled on posedge CLK.
new_game  in  1  pulse; starts a game from Idle or GameOver.
move_start  out  1  level-held START to the mover.
move_done  in  1  DONE from the mover.
lock_start  out  1  one-cycle pulse; write the settled piece into the board.
lock_done  in  1  board write complete.
row_full  in  NUM_ROWS  per-row full flags from the board, valid the cycle after any board change.
clear_row_req  out  1  request to delete a row and shift the rows above it down.
clear_row_idx  out  5  row to clear; stable while clear_row_req is high.
clear_ack  in  1  row clear complete.
spawn_blocked  in  1  the new piece at the spawn position overlaps the board.
piece_type  out  3  active piece, 0..6.
next_piece  out  3  preview piece, 0..6.
level  out  32  current level, 0..MAX_LEVEL.
lines  out  16  total lines cleared; saturates at 16'hFFFF.
score  out  32  score; see Optional Feature.
playing  out  1  high from Spawn through Score.
game_over  out  1  high in GameOver.

Behaviour:
- Reset values: all outputs 0, state Idle, LFSR = LFSR_SEED, scan index = NUM_ROWS-1. next_piece takes the first valid LFSR draw one cycle after reset.
- LFSR: 7-bit, polynomial x^7+x^6+1, steps every cycle. A draw takes lfsr[2:0]. A draw of 7 is rejected and the draw retries on the next cycle. next_piece always holds a value in 0..6.
- State machine:
  - Idle: on new_game, clear lines, level and score, then go to Spawn.
  - Spawn: one cycle. piece_type <= next_piece; next_piece <= new draw.
  - SpawnChk: if spawn_blocked, go to GameOver. Else if move_done is low, go to Move. Otherwise hold in SpawnChk.
  - Move: move_start=1. On move_done=1, go to Lock; move_start is 0 from that cycle on.
  - Lock: lock_start=1 for exactly one cycle, then go to LockWait.
  - LockWait: on lock_done, cleared count = 0, index = NUM_ROWS-1, go to ScanWait.
  - ScanWait: one cycle that lets row_full settle, then go to Scan.
  - Scan: if row_full[index], go to Clear. Else if index == 0, go to Score. Else decrement index and stay in Scan.
  - Clear: clear_row_req=1, clear_row_idx=index, held until clear_ack. Then increment cleared count (max 4) and go to ScanWait with the same index, because the rows above have shifted down.
  - Score: one cycle. lines += cleared count (saturating). Level increments each time the internal line-in-level counter reaches LINES_PER_LEVEL (counter wraps to 0). Level saturates at MAX_LEVEL. Then go to Spawn.
  - GameOver: game_over=1, all requests low. On new_game, go to Idle-clear, then Spawn.
- Only one of move_start, lock_start and clear_row_req is high in any cycle.
- new_game outside Idle and GameOver is ignored.
- RESET asserted mid-operation drops all requests on the next edge. External blocks are reset by the same RESET.
- Responses (move_done, lock_done, clear_ack) arriving in a state that is not waiting for them are ignored.

Optional Feature:
SCORING_EN
- Defined: in Score, score += base × (level+1), using the pre-update level. base is 0/40/100/300/1200 for 0/1/2/3/4 cleared lines. score saturates at 32'hFFFF_FFFF.
- Undefined: score is tied to 0 and no multiplier is built.

Test Plan:
- RESET held 2 cycles, then new_game pulse -> Spawn then SpawnChk. With spawn_blocked=0 and move_done=0, move_start=1 on the 3rd cycle after new_game. piece_type and next_piece are in 0..6.
- move_done raised -> move_start=0 the same registered cycle. lock_start is a single-cycle pulse. No clear_row_req when row_full=0 after lock_done. Next Spawn after 20 Scan cycles.
- row_full bits 19 and 18 set, and the board model shifts rows on clear_ack -> two requests, both with clear_row_idx=19. lines=2. With SCORING_EN at level 0: score=100.
- lines at 9, then a 1-line clear -> lines=10, level=1. Four-line clears repeated past level 19 -> level stays 19.
- spawn_blocked=1 in SpawnChk -> game_over=1, playing=0, move_start stays 0. new_game -> lines=0, level=0, score=0, play resumes.
- RESET asserted while clear_row_req=1 -> next cycle all outputs 0, state Idle. A clear_ack arriving afterwards has no effect.
